// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) constants and helpers for the MixColumns engine.
package aes_pkg;

  localparam int unsigned AES_BYTE_W = 8;
  localparam int unsigned AES_COL_W  = 32;
  localparam int unsigned AES_NCOLS  = 4;

  typedef logic [AES_BYTE_W-1:0]           aes_byte_t;
  typedef logic [AES_COL_W-1:0]            aes_col_t;
  typedef logic [AES_NCOLS*AES_COL_W-1:0]  aes_state_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_t;

  localparam aes_byte_t AES_POLY = 8'h1B;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_columns_engine_if.sv
// Handshake bus between ShiftRows, the MixColumns engine and AddRoundKey.
// inv_mode exists only when MIX_COLUMNS_INV_EN is defined.
interface mix_columns_engine_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_state_t in_state;
  logic       in_last_round;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_state;
`ifdef MIX_COLUMNS_INV_EN
  logic       inv_mode;
`endif

  modport master (
`ifdef MIX_COLUMNS_INV_EN
    output inv_mode,
`endif
    output in_valid, in_state, in_last_round, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
`ifdef MIX_COLUMNS_INV_EN
    input  inv_mode,
`endif
    input  in_valid, in_state, in_last_round, out_ready,
    output in_ready, out_valid, out_state
  );

endinterface

// File: rtl/mix_single_column.sv
// Combinational MixColumns on one column; with MIX_COLUMNS_INV_EN an
// inv_mode input selects InvMixColumns.
module mix_single_column
  import aes_pkg::*;
(
  input  aes_col_t col_in,
`ifdef MIX_COLUMNS_INV_EN
  input  logic     inv_mode,
`endif
  output aes_col_t col_out
);

  aes_byte_t a0, a1, a2, a3;
  aes_byte_t b0, b1, b2, b3;
  aes_byte_t t;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

`ifdef MIX_COLUMNS_INV_EN
  // InvMixColumns = MixColumns x circ(05 00 04 00); apply the sparse factor first.
  aes_byte_t u, v;
  assign u  = inv_mode ? xtime(xtime(a0 ^ a2)) : 8'h00;
  assign v  = inv_mode ? xtime(xtime(a1 ^ a3)) : 8'h00;
  assign b0 = a0 ^ u;
  assign b1 = a1 ^ v;
  assign b2 = a2 ^ u;
  assign b3 = a3 ^ v;
`else
  assign b0 = a0;
  assign b1 = a1;
  assign b2 = a2;
  assign b3 = a3;
`endif

  assign t = b0 ^ b1 ^ b2 ^ b3;

  assign col_out = {b0 ^ t ^ xtime(b0 ^ b1),
                    b1 ^ t ^ xtime(b1 ^ b2),
                    b2 ^ t ^ xtime(b2 ^ b3),
                    b3 ^ t ^ xtime(b3 ^ b0)};

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns stage, COLS_PER_CYCLE columns per busy cycle.
// Optional InvMixColumns support via MIX_COLUMNS_INV_EN.
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_areset,
  mix_columns_engine_if.slave  bus
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Counter value on the busy cycle that writes column 3.
  localparam logic [1:0] LAST_COL = 2'(AES_NCOLS - COLS_PER_CYCLE);
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);

  mc_state_t  state;
  logic [1:0] col;
  aes_state_t work;
  logic       ready_r;
  logic       valid_r;
  logic       inv_sel;

  logic [1:0] idx     [COLS_PER_CYCLE];
  aes_col_t   mix_in  [COLS_PER_CYCLE];
  aes_col_t   mix_out [COLS_PER_CYCLE];

  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
    assign idx[gi]    = col + 2'(gi);
    // Column c sits at bits [127-32c -: 32], i.e. lsb = (3-c)*32 = {~c, 5'b0}.
    assign mix_in[gi] = work[{~idx[gi], 5'b0} +: 32];

    mix_single_column u_mix (
      .col_in   (mix_in[gi]),
`ifdef MIX_COLUMNS_INV_EN
      .inv_mode (inv_sel),
`endif
      .col_out  (mix_out[gi])
    );
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      state   <= IDLE;
      col     <= '0;
      work    <= '0;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      inv_sel <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && ready_r) begin
            work    <= bus.in_state;
            col     <= '0;
            ready_r <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
            inv_sel <= bus.inv_mode;
`else
            inv_sel <= 1'b0;
`endif
            if (bus.in_last_round) begin
              state   <= DONE;
              valid_r <= 1'b1;
            end else begin
              state   <= BUSY;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        BUSY: begin
          for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
            work[{~idx[i], 5'b0} +: 32] <= mix_out[i];
          end
          col <= col + STEP;
          if (col == LAST_COL) begin
            state   <= DONE;
            valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state   <= IDLE;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_r <= 1'b0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready_r;
  assign bus.out_valid = valid_r;
  assign bus.out_state = work;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench for mix_columns_engine: three instances (1, 2, 4 columns per
// cycle) share one stimulus. Define MIX_COLUMNS_INV_EN to add inverse checks.
module tb_mix_columns_engine;
  import aes_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  aes_state_t in_state;
  logic       in_last_round;
  logic       out_ready;
`ifdef MIX_COLUMNS_INV_EN
  logic       inv_mode;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mix_columns_engine_if if1 ();
  mix_columns_engine_if if2 ();
  mix_columns_engine_if if4 ();

  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;  assign if4.in_valid = in_valid;
  assign if1.in_state = in_state;  assign if2.in_state = in_state;  assign if4.in_state = in_state;
  assign if1.in_last_round = in_last_round;
  assign if2.in_last_round = in_last_round;
  assign if4.in_last_round = in_last_round;
  assign if1.out_ready = out_ready; assign if2.out_ready = out_ready; assign if4.out_ready = out_ready;
`ifdef MIX_COLUMNS_INV_EN
  assign if1.inv_mode = inv_mode;  assign if2.inv_mode = inv_mode;  assign if4.inv_mode = inv_mode;
`endif

  mix_columns_engine #(.COLS_PER_CYCLE(1)) u_dut1 (.s00_axi_aclk(clk), .s00_axi_areset(rst), .bus(if1));
  mix_columns_engine #(.COLS_PER_CYCLE(2)) u_dut2 (.s00_axi_aclk(clk), .s00_axi_areset(rst), .bus(if2));
  mix_columns_engine #(.COLS_PER_CYCLE(4)) u_dut4 (.s00_axi_aclk(clk), .s00_axi_areset(rst), .bus(if4));

  logic       ov [3];
  logic       ir [3];
  aes_state_t os [3];
  assign ov[0] = if1.out_valid; assign ov[1] = if2.out_valid; assign ov[2] = if4.out_valid;
  assign ir[0] = if1.in_ready;  assign ir[1] = if2.in_ready;  assign ir[2] = if4.in_ready;
  assign os[0] = if1.out_state; assign os[1] = if2.out_state; assign os[2] = if4.out_state;

  // Cycles from the transfer edge to out_valid, and columns per cycle, per instance.
  int lat  [3] = '{4, 2, 1};
  int cols [3] = '{1, 2, 4};

  localparam aes_state_t V_DB   = 128'hdb135345_db135345_db135345_db135345;
  localparam aes_state_t E_DB   = 128'h8e4da1bc_8e4da1bc_8e4da1bc_8e4da1bc;
  localparam aes_state_t V_MIX  = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5;
  localparam aes_state_t E_MIX  = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6;
  localparam aes_state_t V_FIPS = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam aes_state_t E_FIPS = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam aes_state_t V_LAST = 128'h00112233_44556677_8899aabb_ccddeeff;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input aes_state_t obs, input aes_state_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_valid_c%0d", tag, cols[k]), 128'(ov[k]), 128'(1'b0));
      check($sformatf("%s_ready_c%0d", tag, cols[k]), 128'(ir[k]), 128'(1'b1));
    end
  endtask

  task automatic send(input aes_state_t st, input logic last);
    in_state      = st;
    in_last_round = last;
    in_valid      = 1'b1;
    tick();
    in_valid      = 1'b0;
    in_last_round = 1'b0;
  endtask

  // Called right after the transfer edge; walks four more edges checking timing.
  task automatic window(input string tag, input aes_state_t exp, input logic last,
                        input logic chk, output aes_state_t res);
    logic exp_v;
    res = '0;
    for (int e = 0; e <= 4; e++) begin
      for (int k = 0; k < 3; k++) begin
        exp_v = last || (e >= lat[k]);
        check($sformatf("%s_valid_c%0d_e%0d", tag, cols[k], e), 128'(ov[k]), 128'(exp_v));
        check($sformatf("%s_ready_c%0d_e%0d", tag, cols[k], e), 128'(ir[k]), 128'(1'b0));
        if (exp_v && chk)
          check($sformatf("%s_state_c%0d_e%0d", tag, cols[k], e), os[k], exp);
      end
      if (e == 4) res = os[0];
      else        tick();
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle_all(tag);
  endtask

  task automatic run_txn(input string tag, input aes_state_t st, input aes_state_t exp,
                         input logic last);
    aes_state_t res;
    send(st, last);
    window(tag, exp, last, 1'b1, res);
    release_out({tag, "_ret"});
  endtask

  initial begin
    aes_state_t res;
    aes_state_t rnd;
    in_valid      = 1'b0;
    in_state      = '0;
    in_last_round = 1'b0;
    out_ready     = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
    inv_mode      = 1'b0;
`endif
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid_c%0d", cols[k]), 128'(ov[k]), 128'(1'b0));
      check($sformatf("rst_ready_c%0d", cols[k]), 128'(ir[k]), 128'(1'b0));
      check($sformatf("rst_state_c%0d", cols[k]), os[k], '0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready_before_edge", 128'(ir[0]), 128'(1'b0));
    tick();
    check_idle_all("post_rst");

    run_txn("db",   V_DB,   E_DB,   1'b0);
    run_txn("mix",  V_MIX,  E_MIX,  1'b0);
    run_txn("fips", V_FIPS, E_FIPS, 1'b0);
    run_txn("last", V_LAST, V_LAST, 1'b1);

    // Backpressure: hold DONE for 10 cycles while upstream offers another word.
    send(V_FIPS, 1'b0);
    for (int e = 0; e < 4; e++) tick();
    in_state = V_DB;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("hold_valid_c%0d_%0d", cols[k], c), 128'(ov[k]), 128'(1'b1));
        check($sformatf("hold_ready_c%0d_%0d", cols[k], c), 128'(ir[k]), 128'(1'b0));
        check($sformatf("hold_state_c%0d_%0d", cols[k], c), os[k], E_FIPS);
      end
      tick();
    end
    in_valid = 1'b0;
    release_out("hold_ret");

    // Reset while the 1- and 2-column engines are still busy.
    send(V_MIX, 1'b0);
    tick();
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midrst_valid_c%0d", cols[k]), 128'(ov[k]), 128'(1'b0));
      check($sformatf("midrst_ready_c%0d", cols[k]), 128'(ir[k]), 128'(1'b0));
      check($sformatf("midrst_state_c%0d", cols[k]), os[k], '0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_idle_all("midrst_release");
    run_txn("after_rst", V_MIX, E_MIX, 1'b0);

`ifdef MIX_COLUMNS_INV_EN
    inv_mode = 1'b1;
    run_txn("inv_db", E_DB, V_DB, 1'b0);
    run_txn("inv_fips", E_FIPS, V_FIPS, 1'b0);
    for (int r = 0; r < 3; r++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      inv_mode = 1'b0;
      send(rnd, 1'b0);
      window($sformatf("rt_fwd%0d", r), '0, 1'b0, 1'b0, res);
      release_out($sformatf("rt_fwd%0d_ret", r));
      inv_mode = 1'b1;
      run_txn($sformatf("rt_inv%0d", r), res, rnd, 1'b0);
    end
    inv_mode = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
